// File: rtl/pixel_pattern_gen.sv
// Registered test-pattern generator: maps VGA coordinates to a pixel_on bit for one of
// four runtime-selectable patterns. Mode changes are deferred to frame boundaries.
module pixel_pattern_gen #(
    parameter int COORD_W     = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SPLIT_Y     = 240,
    parameter int SQ_LOG2     = 5,
    parameter int SCROLL_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic [1:0]         mode_sel,
    input  logic               mode_req,
    output logic               pixel_on,
    output logic [1:0]         mode_active,
    output logic [7:0]         frame_cnt
);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    typedef enum logic [1:0] {
        MODE_HSPLIT  = 2'd0,
        MODE_VSPLIT  = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BAR     = 2'd3
    } mode_e;

    // Compares run one bit wider so the bar's wrapped distance never overflows.
    localparam wide_t H_ACT_W  = wide_t'(H_ACTIVE);
    localparam wide_t V_ACT_W  = wide_t'(V_ACTIVE);
    localparam wide_t H_HALF_W = wide_t'(H_ACTIVE / 2);
    localparam wide_t SPLIT_W  = wide_t'(SPLIT_Y);
    localparam wide_t BAR_H_W  = wide_t'(2 ** SQ_LOG2);
    localparam wide_t STEP_W   = wide_t'(SCROLL_STEP);

    mode_e      mode_q, mode_d;
    mode_e      pend_mode_q, pend_mode_d;
    logic       pend_valid_q, pend_valid_d;
    coord_t     offset_q, offset_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       pixel_q, pixel_d;

    wide_t x_w, y_w, off_w, bar_dist, step_sum;
    logic  pattern_on;

    // Pattern evaluation always uses the mode held before this edge, so a
    // boundary switch shows up one clock after frame_start.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pattern_on = 1'b0;
        x_w        = {1'b0, x};
        y_w        = {1'b0, y};
        off_w      = {1'b0, offset_q};
        bar_dist   = (y_w >= off_w) ? (y_w - off_w) : (y_w + V_ACT_W - off_w);

        unique case (mode_q)
            MODE_HSPLIT:  pattern_on = (y_w < SPLIT_W);
            MODE_VSPLIT:  pattern_on = (x_w < H_HALF_W);
            MODE_CHECKER: pattern_on = ~(x[SQ_LOG2] ^ y[SQ_LOG2]);
            MODE_BAR:     pattern_on = (bar_dist < BAR_H_W);
            default:      pattern_on = 1'b0;
        endcase

        pixel_d = video_on && (x_w < H_ACT_W) && (y_w < V_ACT_W) && pattern_on;
    end

    always_comb begin
        mode_d       = mode_q;
        pend_mode_d  = pend_mode_q;
        pend_valid_d = pend_valid_q;
        offset_d     = offset_q;
        fcnt_d       = fcnt_q;
        step_sum     = {1'b0, offset_q} + STEP_W;

        if (frame_start) begin
            fcnt_d       = fcnt_q + 8'd1;
            pend_valid_d = 1'b0;
            if (mode_req) begin
                mode_d = mode_e'(mode_sel);
            end else if (pend_valid_q) begin
                mode_d = pend_mode_q;
            end
            // Entering the bar mode restarts the bar at the top of the screen.
            if (mode_d == MODE_BAR && mode_q != MODE_BAR) begin
                offset_d = '0;
            end else begin
                offset_d = coord_t'((step_sum >= V_ACT_W) ? (step_sum - V_ACT_W) : step_sum);
            end
        end else if (mode_req) begin
            pend_mode_d  = mode_e'(mode_sel);
            pend_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_HSPLIT;
            pend_mode_q  <= MODE_HSPLIT;
            pend_valid_q <= 1'b0;
            offset_q     <= '0;
            fcnt_q       <= '0;
            pixel_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            pend_mode_q  <= pend_mode_d;
            pend_valid_q <= pend_valid_d;
            offset_q     <= offset_d;
            fcnt_q       <= fcnt_d;
            pixel_q      <= pixel_d;
        end
    end

    assign pixel_on    = pixel_q;
    assign mode_active = mode_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Scoreboard bench for pixel_pattern_gen: a driver pushes expectations from an
// arithmetic reference model, a monitor pops and compares one entry per clock.
module tb_pixel_pattern_gen;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int SPLIT   = 240;
    localparam int SQ      = 32;
    localparam int STEP    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       video_on = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] mode_sel = '0;
    logic       mode_req = 1'b0;
    logic       pixel_on;
    logic [1:0] mode_active;
    logic [7:0] frame_cnt;

    pixel_pattern_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .mode_sel    (mode_sel),
        .mode_req    (mode_req),
        .pixel_on    (pixel_on),
        .mode_active (mode_active),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pix;
        logic [1:0] mode;
        logic [7:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int m_mode = 0;
    int m_pend = 0;
    bit m_pv   = 1'b0;
    int m_off  = 0;
    int m_fcnt = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pix(input int xi, input int yi, input bit von,
                                     input int md, input int off);
        if (!von || xi >= H_ACT || yi >= V_ACT) return 1'b0;
        case (md)
            0: return yi < SPLIT;
            1: return xi < H_ACT / 2;
            2: return ((xi / SQ + yi / SQ) % 2) == 0;
            default: return ((yi - off + V_ACT) % V_ACT) < SQ;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_pv = 1'b0; m_off = 0; m_fcnt = 0;
    endtask

    task automatic step(input int xi, input int yi, input bit von, input bit fs,
                        input int sel, input bit req);
        exp_t e;
        int   new_mode;
        @(negedge clk);
        x = 10'(xi); y = 10'(yi); video_on = von;
        frame_start = fs; mode_sel = 2'(sel); mode_req = req;
        e.pix = model_pix(xi, yi, von, m_mode, m_off);
        if (fs) begin
            m_fcnt   = (m_fcnt + 1) % 256;
            new_mode = req ? sel : (m_pv ? m_pend : m_mode);
            m_off    = (new_mode == 3 && m_mode != 3) ? 0 : (m_off + STEP) % V_ACT;
            m_mode   = new_mode;
            m_pv     = 1'b0;
        end else if (req) begin
            m_pend = sel;
            m_pv   = 1'b1;
        end
        e.mode = 2'(m_mode);
        e.fcnt = 8'(m_fcnt);
        sb.push_back(e);
    endtask

    task automatic pix(input int xi, input int yi);
        step(xi, yi, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic frame();
        step($urandom_range(0, 700), $urandom_range(0, 520), 1'b1, 1'b1, 0, 1'b0);
    endtask

    // Monitor: the entry pushed at a falling edge is due just after the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("pixel_on", int'(pixel_on), int'(e.pix));
                check("mode_active", int'(mode_active), int'(e.mode));
                check("frame_cnt", int'(frame_cnt), int'(e.fcnt));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("reset_pixel_on", int'(pixel_on), 0);
        check("reset_mode_active", int'(mode_active), 0);
        check("reset_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 split, blanking and range limits
        pix(100, 239);
        pix(100, 240);
        step(100, 10, 1'b0, 1'b0, 0, 1'b0);
        pix(640, 10);
        pix(639, 479);
        pix(100, 480);

        // Deferred request for the checkerboard
        step(50, 50, 1'b1, 1'b0, 2, 1'b1);
        pix(100, 10);
        pix(100, 300);
        frame();
        pix(0, 0);
        pix(32, 0);
        pix(32, 32);
        pix(31, 31);

        // Last request wins; bar enters at the top
        step(10, 10, 1'b1, 1'b0, 1, 1'b1);
        pix(10, 10);
        step(10, 10, 1'b1, 1'b0, 3, 1'b1);
        frame();
        for (int yy = 0; yy < 40; yy++) pix($urandom_range(0, 639), yy);
        pix(5, 479);

        // Bar offset wraps around the bottom
        for (int f = 0; f < 470; f++) frame();
        pix(10, 475);
        pix(10, 5);
        pix(10, 22);
        pix(10, 6);
        pix(10, 469);
        for (int f = 0; f < 10; f++) frame();
        pix(10, 0);
        pix(10, 31);
        pix(10, 32);

        // Request coincident with a frame boundary
        step(10, 10, 1'b1, 1'b1, 1, 1'b1);
        pix(319, 10);
        pix(320, 10);
        frame();
        pix(319, 10);

        // Frame counter wrap
        for (int f = 0; f < 256; f++) frame();
        pix(100, 100);

        // Randomised traffic across all modes
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 700), $urandom_range(0, 520),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 29) == 0);
        end

        // Asynchronous reset in mid-line with the pixel lit and mode nonzero
        step(10, 10, 1'b1, 1'b1, 1, 1'b1);
        pix(100, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check("async_pixel_on", int'(pixel_on), 0);
        check("async_mode_active", int'(mode_active), 0);
        check("async_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pix(100, 239);
        pix(100, 240);
        frame();
        pix(100, 239);
        pix(0, 0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_pattern_gen.md
Name: pixel_pattern_gen

Overview:
- Parametrised, registered successor to the fixed half-screen test-pattern block.
- Takes pixel coordinates from the VGA timing generator and produces one pixel_on bit per clock.
- Supports four runtime-selectable patterns. Mode changes take effect only on frame boundaries, so there is no tearing.
- Adds an animated scrolling bar driven by a frame counter. Sits between the VGA timing generator and the colour mapper.

Parameters:
- COORD_W, 10, width of x/y coordinate buses
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SPLIT_Y, 240, first line that is off in mode 0
- SQ_LOG2, 5, log2 of checker square size and scroll-bar height (32 px)
- SCROLL_STEP, 1, lines the bar advances per frame; must be < V_ACTIVE

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x  in  COORD_W  current pixel column
- y  in  COORD_W  current pixel row
- video_on  in  1  high during active video
- frame_start  in  1  one-cycle pulse at start of each frame
- mode_sel  in  2  requested pattern
- mode_req  in  1  one-cycle strobe that captures mode_sel
- pixel_on  out  1  registered pixel value
- mode_active  out  2  pattern currently applied
- frame_cnt  out  8  frames since reset, wraps 255->0

Behaviour:
- Reset (async assert on rst_n low, sync release on clk): pixel_on=0, mode_active=0, pending mode=0, pending-valid=0, scroll offset=0, frame_cnt=0.
- Latency: pixel_on is valid exactly 1 clk after the x/y/video_on it corresponds to. There is no other pipeline state.
- Blanking and range check: pixel_on=0 when video_on=0, x>=H_ACTIVE or y>=V_ACTIVE, regardless of mode.
- Mode 0 (horizontal split): on iff y<SPLIT_Y.
- Mode 1 (vertical split): on iff x<H_ACTIVE/2.
- Mode 2 (checkerboard): on iff bit SQ_LOG2 of x XOR bit SQ_LOG2 of y = 0, i.e. square (0,0) is on.
- Mode 3 (scrolling bar):
  - d = y-offset if y>=offset, else y+V_ACTIVE-offset.
  - on iff d < 2^SQ_LOG2.
  - The bar wraps from the bottom to the top of the screen.
- Mode request:
  - mode_req high -> pending mode <= mode_sel and pending-valid <= 1.
  - A later mode_req before the frame boundary overwrites the pending mode; the last request wins.
- Frame boundary (frame_start high):
  - frame_cnt increments, wrapping mod 256.
  - If pending-valid: mode_active <= pending mode, pending-valid <= 0.
  - mode_req and frame_start in the same cycle: that cycle's mode_sel is applied directly at this boundary, and pending-valid ends at 0.
  - The new mode affects pixel_on from the next clock onward.
- Scroll offset:
  - Updates on every frame_start: offset+SCROLL_STEP, minus V_ACTIVE if the sum is >=V_ACTIVE.
  - Offset is held in COORD_W bits, with one extra bit for the intermediate sum.
  - It advances in all modes.
  - When a frame boundary switches mode_active from a value other than 3 to 3, offset <= 0 instead, so the bar always enters at the top.
- Arithmetic: all compares are unsigned. No multipliers; H_ACTIVE/2 is a constant.
- frame_start during active video is legal: the mode switch applies mid-frame with no other side effect.
- rst_n asserted mid-frame: pixel_on drops to 0 immediately (async), and all state returns to reset values.

Test Plan:
- Reset then mode 0, video_on=1, x=100: y=239 -> pixel_on=1 one clk later; y=240 -> 0; video_on=0 with y=10 -> 0; x=640 -> 0.
- mode_req with mode_sel=2 at mid-frame: mode_active stays 0 and pattern unchanged until frame_start. Then x=0,y=0 -> 1; x=32,y=0 -> 0; x=32,y=32 -> 1.
- Two mode_req (1 then 3) within one frame: next frame_start gives mode_active=3 and offset=0; y=0..31 on, y=32 off.
- Mode 3, 470 frame_starts after entry: offset=470. y=475 -> 1, y=5 -> 1 (wrapped, d=15), y=22 -> 0 (d=32). Ten more frames -> offset=0.
- mode_req (sel=1) coincident with frame_start: mode_active=1 next clk; x=319 -> 1, x=320 -> 0; no pending change at the following frame.
- 256 frame_starts -> frame_cnt wraps to 0. rst_n low mid-line -> pixel_on=0 within the same cycle; all outputs at reset values.
